// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage wrapper around an external 32-bit ALU.
//   Two-stage valid/ready pipeline: ISS holds the decoded instruction and
//   drives the ALU operands/op; RES captures the ALU result and zero flag
//   and presents them to MEM.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_*              decoded instruction from ID, in_valid/in_ready handshake
//   alu_a/b/op        ALU operands and op code (op[2]=sub, op[1:0]=and/or/add/slt)
//   alu_z/alu_zero    combinational ALU return
//   out_*             registered result to MEM, out_valid/out_ready handshake
// Optional feature: define ALU_ISSUE_FWD_EN to forward RES -> ALU operands.
module alu_issue_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_opcode,
  input  logic [5:0]    in_funct,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic [W-1:0]  in_rs_val,
  input  logic [W-1:0]  in_rt_val,
  input  logic [15:0]   in_imm,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_op,
  input  logic [W-1:0]  alu_z,
  input  logic          alu_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_result,
  output logic          out_zero,
  output logic [RW-1:0] out_dest,
  output logic          out_illegal
);

  // ISS stage
  logic          r_iss_valid;
  logic [W-1:0]  r_iss_a;
  logic [W-1:0]  r_iss_b;
  logic [2:0]    r_iss_op;
  logic [RW-1:0] r_iss_dest;
  logic          r_iss_ill;
  // RES stage
  logic          r_out_valid;
  logic [W-1:0]  r_out_result;
  logic          r_out_zero;
  logic [RW-1:0] r_out_dest;
  logic          r_out_ill;

  logic w_res_adv, w_iss_adv, w_accept;
  assign w_res_adv = !r_out_valid || out_ready;
  assign w_iss_adv = r_iss_valid && w_res_adv;
  assign in_ready  = !r_iss_valid || w_res_adv;
  assign w_accept  = in_valid && in_ready;

  // Decode
  logic [2:0]    w_op;
  logic [W-1:0]  w_b;
  logic [RW-1:0] w_dest;
  logic          w_ill;
  logic          w_use_rt;  // B operand is a register value (forwardable)
  logic [W-1:0]  w_sext, w_zext;
  assign w_sext = {{(W-16){in_imm[15]}}, in_imm};
  assign w_zext = {{(W-16){1'b0}}, in_imm};

  always_comb begin
    w_op     = 3'b010;
    w_b      = in_rt_val;
    w_dest   = '0;
    w_ill    = 1'b0;
    w_use_rt = 1'b0;
    case (in_opcode)
      6'h00: begin
        w_dest   = in_rd;
        w_use_rt = 1'b1;
        case (in_funct)
          6'h20:   w_op = 3'b010;
          6'h22:   w_op = 3'b110;
          6'h24:   w_op = 3'b000;
          6'h25:   w_op = 3'b001;
          6'h2A:   w_op = 3'b111;
          default: begin
            w_ill    = 1'b1;
            w_dest   = '0;
            w_use_rt = 1'b0;
          end
        endcase
      end
      6'h08: begin w_op = 3'b010; w_b = w_sext; w_dest = in_rt; end
      6'h0A: begin w_op = 3'b111; w_b = w_sext; w_dest = in_rt; end
      6'h0C: begin w_op = 3'b000; w_b = w_zext; w_dest = in_rt; end
      6'h0D: begin w_op = 3'b001; w_b = w_zext; w_dest = in_rt; end
      6'h23: begin w_op = 3'b010; w_b = w_sext; w_dest = in_rt; end
      6'h2B: begin w_op = 3'b010; w_b = w_sext; end
      6'h04: begin w_op = 3'b110; w_use_rt = 1'b1; end
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid <= 1'b0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_iss_op    <= 3'b000;
      r_iss_dest  <= '0;
      r_iss_ill   <= 1'b0;
    end else if (w_accept) begin
      r_iss_valid <= 1'b1;
      r_iss_a     <= in_rs_val;
      r_iss_b     <= w_b;
      r_iss_op    <= w_op;
      r_iss_dest  <= w_dest;
      r_iss_ill   <= w_ill;
    end else if (w_iss_adv) begin
      r_iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_dest   <= '0;
      r_out_ill    <= 1'b0;
    end else if (w_iss_adv) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_z;
      r_out_zero   <= alu_zero;
      r_out_dest   <= r_iss_dest;
      r_out_ill    <= r_iss_ill;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  // Source register numbers kept alongside ISS for the RES -> ALU bypass.
  logic [RW-1:0] r_iss_rs, r_iss_rt;
  logic          r_iss_use_rt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_rs     <= '0;
      r_iss_rt     <= '0;
      r_iss_use_rt <= 1'b0;
    end else if (w_accept) begin
      r_iss_rs     <= in_rs;
      r_iss_rt     <= in_rt;
      r_iss_use_rt <= w_use_rt;
    end
  end

  logic w_fwd_a, w_fwd_b;
  assign w_fwd_a = r_out_valid && (r_out_dest != '0) && (r_iss_rs == r_out_dest);
  assign w_fwd_b = r_out_valid && (r_out_dest != '0) && r_iss_use_rt &&
                   (r_iss_rt == r_out_dest);
  assign alu_a = w_fwd_a ? r_out_result : r_iss_a;
  assign alu_b = w_fwd_b ? r_out_result : r_iss_b;
`else
  // ID resolves hazards; register numbers only matter for dest selection.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{in_rs, w_use_rt};
  assign alu_a = r_iss_a;
  assign alu_b = r_iss_b;
`endif

  assign alu_op      = r_iss_op;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_dest    = r_out_dest;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an ALU model on the operand
// outputs and a scoreboard of expected MEM-side results.
module tb_alu_issue_stage;
  localparam int W = 32, RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_opcode = '0, in_funct = '0;
  logic [RW-1:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [W-1:0]  in_rs_val = '0, in_rt_val = '0;
  logic [15:0]   in_imm = '0;
  logic [W-1:0]  alu_a, alu_b, alu_z;
  logic [2:0]    alu_op;
  logic          alu_zero;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          out_zero, out_illegal;
  logic [RW-1:0] out_dest;

  always #5 clk = ~clk;

  alu_issue_stage #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_dest(out_dest), .out_illegal(out_illegal)
  );

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, b);
    case (op[1:0])
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return op[2] ? a - b : a + b;
      default: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
  endfunction

  // External ALU
  assign alu_z    = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_z == '0);

  typedef struct {
    logic [W-1:0]  res;
    logic          zero;
    logic [RW-1:0] dest;
    logic          ill;
  } exp_t;

  exp_t q[$];
  exp_t nxt;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decode + ALU for one instruction, no forwarding.
  function automatic exp_t model(input logic [5:0] opc, fn, input logic [RW-1:0] rt, rd,
                                 input logic [W-1:0] a, rtv, input logic [15:0] imm);
    exp_t e;
    logic [2:0] op;
    logic [W-1:0] b, se, ze;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    op = 3'b010; b = rtv; e.dest = '0; e.ill = 1'b0;
    if (opc == 6'h00) begin
      e.dest = rd;
      if      (fn == 6'h20) op = 3'b010;
      else if (fn == 6'h22) op = 3'b110;
      else if (fn == 6'h24) op = 3'b000;
      else if (fn == 6'h25) op = 3'b001;
      else if (fn == 6'h2A) op = 3'b111;
      else begin e.ill = 1'b1; e.dest = '0; end
    end
    else if (opc == 6'h08) begin b = se; e.dest = rt; end
    else if (opc == 6'h0A) begin op = 3'b111; b = se; e.dest = rt; end
    else if (opc == 6'h0C) begin op = 3'b000; b = ze; e.dest = rt; end
    else if (opc == 6'h0D) begin op = 3'b001; b = ze; e.dest = rt; end
    else if (opc == 6'h23) begin b = se; e.dest = rt; end
    else if (opc == 6'h2B) begin b = se; end
    else if (opc == 6'h04) begin op = 3'b110; end
    else e.ill = 1'b1;
    e.res  = alu_f(op, a, b);
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic put(input logic [5:0] opc, fn, input logic [RW-1:0] rs, rt, rd,
                     input logic [W-1:0] rsv, rtv, input logic [15:0] imm);
    in_opcode = opc; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_val = rsv; in_rt_val = rtv; in_imm = imm; in_valid = 1'b1;
    nxt = model(opc, fn, rt, rd, rsv, rtv, imm);
  endtask

  // One clock: score the output being consumed, record an accepted input.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_output", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_zero", {31'h0, out_zero}, {31'h0, e.zero});
        chk("sb_dest", {27'h0, out_dest}, {27'h0, e.dest});
        chk("sb_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
      end
    end
    if (acc) q.push_back(nxt);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(a);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    bit a;
    int idx, c, nacc;
    // Reset state
    #3;
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_in_ready", {31'h0, in_ready}, 1);
    chk("rst_alu_op", {29'h0, alu_op}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", {29'h0, out_zero, out_illegal, |out_dest}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // add 5+7 -> r9, latency one edge after accept
    put(6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 16'h0);
    tick(a);
    chk("add_accepted", {31'h0, a}, 1);
    in_valid = 1'b0;
    chk("add_alu_op", {29'h0, alu_op}, 3'b010);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_not_yet_valid", {31'h0, out_valid}, 0);
    tick(a);
    chk("add_out_valid", {31'h0, out_valid}, 1);
    chk("add_out_result", out_result, 12);
    drain();

    // beq equal operands
    put(6'h04, 6'h00, 5'd1, 5'd2, 5'd7, 32'h1234, 32'h1234, 16'h0010);
    tick(a); in_valid = 1'b0;
    chk("beq_alu_op", {29'h0, alu_op}, 3'b110);
    tick(a);
    chk("beq_zero", {31'h0, out_zero}, 1);
    chk("beq_dest", {27'h0, out_dest}, 0);
    drain();

    // slti -1 < 1
    put(6'h0A, 6'h00, 5'd1, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'h0, 16'h0001);
    tick(a); in_valid = 1'b0; tick(a);
    chk("slti_result", out_result, 1);
    drain();

    // ori zero-extends, addi sign-extends
    put(6'h0D, 6'h00, 5'd1, 5'd5, 5'd0, 32'h0000_0001, 32'h0, 16'h8000);
    tick(a); in_valid = 1'b0;
    chk("ori_alu_b", alu_b, 32'h0000_8000);
    drain();
    put(6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 32'h0000_0001, 32'h0, 16'h8000);
    tick(a); in_valid = 1'b0;
    chk("addi_alu_b", alu_b, 32'hFFFF_8000);
    drain();

    // Stream 4 with out_ready low for 3 cycles
    idx = 0; nacc = 0;
    for (c = 0; c < 30 && idx < 4; c++) begin
      put(6'h08, 6'h00, 5'd2, 5'(idx + 1), 5'd0, 32'(100 * idx), 32'h0, 16'(idx + 1));
      out_ready = (c >= 3);
      if (c == 2) begin
        #1;
        chk("stall_in_ready", {31'h0, in_ready}, 0);
        chk("stall_accepts", nacc, 2);
      end
      tick(a);
      if (a) begin idx++; nacc++; end
    end
    chk("stream_all_accepted", idx, 4);
    drain();

    // Back-to-back dependent adds: r3 = 1+2, r4 = r3+r3 with stale values
    put(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0);
    tick(a);
    put(6'h00, 6'h20, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 16'h0);
`ifdef ALU_ISSUE_FWD_EN
    nxt.res = 32'd6; nxt.zero = 1'b0;
`else
    nxt.res = 32'd0; nxt.zero = 1'b1;
`endif
    tick(a);
    drain();

    // Illegal opcode still flows through
    put(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 16'h0);
    tick(a); in_valid = 1'b0; tick(a);
    chk("ill_flag", {31'h0, out_illegal}, 1);
    chk("ill_dest", {27'h0, out_dest}, 0);
    drain();

    // Async reset mid-stream drops in-flight work
    put(6'h08, 6'h00, 5'd1, 5'd8, 5'd0, 32'd10, 32'd0, 16'd1);
    tick(a);
    put(6'h08, 6'h00, 5'd1, 5'd9, 5'd0, 32'd20, 32'd0, 16'd2);
    tick(a);
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'h0, out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 0);
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", {31'h0, in_ready}, 1);
    tick(a);
    chk("postrst_no_output", {31'h0, out_valid}, 0);
    put(6'h00, 6'h25, 5'd1, 5'd2, 5'd10, 32'h0F0, 32'h00F, 16'h0);
    tick(a);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
